// File: rtl/xor_bus_master.sv
// Bus-initiator decrypt engine: reads a key and N_CHARS words over sysbus, writes XOR results back.
// Optional XNOR mode is compiled in with the XOR_BUS_MASTER_XNOR_EN macro.
module xor_bus_master #(
    parameter int WORD_W   = 10,
    parameter int OP_W     = 3,
    parameter int N_CHARS  = 8,
    parameter int SRC_BASE = 64,
    parameter int DST_BASE = 72,
    parameter int KEY_ADDR = 80
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic              start,
    input  logic              mode,
    input  logic              bus_gnt,
    output logic              bus_req,
    output logic              busy,
    output logic              done,
    output logic              load_MAR,
    output logic              load_MDR,
    output logic              CS,
    output logic              R_NW,
    output logic              MDR_bus,
    inout  wire  [WORD_W-1:0] sysbus
);

    localparam int AW = WORD_W - OP_W;
    localparam int IW = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;

    typedef enum logic [3:0] {
        IDLE, REQ,
        KEY_A, KEY_R, KEY_C,
        SRC_A, SRC_R, SRC_C,
        DST_A, DST_D, DST_W,
        NEXT, DONE,
        HOLD_KEY, HOLD_CHR
    } state_t;

    state_t            state;
    logic [IW-1:0]     idx;
    logic [WORD_W-1:0] key;
    logic [WORD_W-1:0] data;
    logic [WORD_W-1:0] result;
    logic              last;

    assign last = (idx == IW'(N_CHARS - 1));

`ifdef XOR_BUS_MASTER_XNOR_EN
    logic mode_q;

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset)
            mode_q <= 1'b0;
        else if (state == IDLE && start)
            mode_q <= mode;
    end

    assign result = mode_q ? ~(data ^ key) : (data ^ key);
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign result      = data ^ key;
`endif

    // Any grant loss parks in a hold state; the hold state picks the replay point.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
            idx   <= '0;
            key   <= '0;
            data  <= '0;
        end else begin
            case (state)
                IDLE:     if (start) state <= REQ;
                REQ: begin
                    idx <= '0;
                    if (bus_gnt) state <= KEY_A;
                end
                KEY_A:    state <= bus_gnt ? KEY_R : HOLD_KEY;
                KEY_R:    state <= bus_gnt ? KEY_C : HOLD_KEY;
                KEY_C: begin
                    if (bus_gnt) begin
                        key   <= sysbus;
                        state <= SRC_A;
                    end else begin
                        state <= HOLD_KEY;
                    end
                end
                SRC_A:    state <= bus_gnt ? SRC_R : HOLD_CHR;
                SRC_R:    state <= bus_gnt ? SRC_C : HOLD_CHR;
                SRC_C: begin
                    if (bus_gnt) begin
                        data  <= sysbus;
                        state <= DST_A;
                    end else begin
                        state <= HOLD_CHR;
                    end
                end
                DST_A:    state <= bus_gnt ? DST_D : HOLD_CHR;
                DST_D:    state <= bus_gnt ? DST_W : HOLD_CHR;
                DST_W:    state <= bus_gnt ? NEXT  : HOLD_CHR;
                // The write is already committed here, so a grant loss still advances idx.
                NEXT: begin
                    if (last) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + IW'(1);
                        state <= bus_gnt ? SRC_A : HOLD_CHR;
                    end
                end
                DONE:     state <= IDLE;
                HOLD_KEY: if (bus_gnt) state <= KEY_A;
                HOLD_CHR: if (bus_gnt) state <= SRC_A;
                default:  state <= IDLE;
            endcase
        end
    end

    logic              s_mar, s_mdr, s_cs, s_rnw, s_mdrbus, s_drive;
    logic [AW-1:0]     addr;
    logic [WORD_W-1:0] drive_val;

    always_comb begin
        s_mar    = 1'b0;
        s_mdr    = 1'b0;
        s_cs     = 1'b0;
        s_rnw    = 1'b0;
        s_mdrbus = 1'b0;
        s_drive  = 1'b0;
        addr     = AW'(SRC_BASE) + AW'(idx);
        case (state)
            KEY_A: begin
                s_mar   = 1'b1;
                s_drive = 1'b1;
                addr    = AW'(KEY_ADDR);
            end
            SRC_A: begin
                s_mar   = 1'b1;
                s_drive = 1'b1;
            end
            KEY_R, SRC_R: begin
                s_cs  = 1'b1;
                s_rnw = 1'b1;
            end
            KEY_C, SRC_C: s_mdrbus = 1'b1;
            DST_A: begin
                s_mar   = 1'b1;
                s_drive = 1'b1;
                addr    = AW'(DST_BASE) + AW'(idx);
            end
            DST_D: begin
                s_mdr   = 1'b1;
                s_drive = 1'b1;
            end
            DST_W:   s_cs = 1'b1;
            default: ;
        endcase
    end

    assign drive_val = (state == DST_D) ? result : WORD_W'(addr);

    // Grant gating is combinational so the bus is released in the cycle the grant drops.
    assign load_MAR = s_mar    & bus_gnt;
    assign load_MDR = s_mdr    & bus_gnt;
    assign CS       = s_cs     & bus_gnt;
    assign R_NW     = s_rnw    & bus_gnt;
    assign MDR_bus  = s_mdrbus & bus_gnt;
    assign sysbus   = (s_drive && bus_gnt) ? drive_val : 'z;

    assign busy    = (state != IDLE);
    assign bus_req = (state != IDLE);
    assign done    = (state == DONE);

endmodule
